// File: rtl/mul64_seq_ctrl.sv
// Sequential 64x64 unsigned multiplier: one shared 32x32 multiplier walks LL/LH/HL/HH
// partial products into a 128-bit accumulator. Optional tag path under `MUL_SEQ_TAG_EN`.

module multiplier_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] p_o
);
  assign p_o = {32'b0, a_i} * {32'b0, b_i};
endmodule

module mul64_seq_ctrl #(
  parameter int SKIP_ZERO = 1
`ifdef MUL_SEQ_TAG_EN
  ,
  parameter int TAG_W = 4
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [63:0]          x_i,
  input  logic [63:0]          y_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         p_o,
`ifdef MUL_SEQ_TAG_EN
  input  logic [TAG_W-1:0]     tag_i,
  output logic [TAG_W-1:0]     tag_o,
`endif
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S_LL = 3'd1,
    S_LH = 3'd2,
    S_HL = 3'd3,
    S_HH = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t         state_q;
  logic [63:0]    x_q, y_q;
  logic [127:0]   acc_q, acc_d;
  logic [127:0]   p_q;
  logic           out_valid_q;
  logic [31:0]    mul_a, mul_b;
  logic [63:0]    prod;
  logic [127:0]   term;
  logic           accept;
  state_t         step_d, first_d;

  // Step index: bit1 selects the X half, bit0 selects the Y half (00=LL ... 11=HH).
  function automatic logic step_runs(input logic [1:0] idx, input logic [63:0] x,
                                     input logic [63:0] y);
    logic [31:0] a, b;
    a = idx[1] ? x[63:32] : x[31:0];
    b = idx[0] ? y[63:32] : y[31:0];
    if (SKIP_ZERO == 0) return 1'b1;
    return (a != 32'd0) && (b != 32'd0);
  endfunction

  function automatic state_t next_from(input logic [2:0] start, input logic [63:0] x,
                                       input logic [63:0] y);
    state_t r;
    r = DONE;
    for (int i = 3; i >= 0; i--) begin
      if (i >= int'(start) && step_runs(i[1:0], x, y)) r = state_t'(3'(i) + 3'd1);
    end
    return r;
  endfunction

  multiplier_32 u_mul (
    .a_i(mul_a),
    .b_i(mul_b),
    .p_o(prod)
  );

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign p_o       = p_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    mul_a = (state_q inside {S_HL, S_HH}) ? x_q[63:32] : x_q[31:0];
    mul_b = (state_q inside {S_LH, S_HH}) ? y_q[63:32] : y_q[31:0];
    case (state_q)
      S_LL:       term = {64'b0, prod};
      S_LH, S_HL: term = {32'b0, prod, 32'b0};
      S_HH:       term = {prod, 64'b0};
      default:    term = '0;
    endcase
    acc_d   = acc_q + term;
    // Each step state's encoding equals the index of the step after it.
    step_d  = next_from(state_q, x_q, y_q);
    first_d = next_from(3'd0, x_i, y_i);
  end

`ifdef MUL_SEQ_TAG_EN
  logic [TAG_W-1:0] tag_q;
  assign tag_o = tag_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tag_q <= '0;
    else if (accept) tag_q <= tag_i;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_LL, S_LH, S_HL, S_HH: begin
          acc_q   <= acc_d;
          state_q <= step_d;
          if (step_d == DONE) begin
            p_q         <= acc_d;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: ;
      endcase
      // Accept overrides the DONE->IDLE drain so back-to-back requests lose no cycle.
      if (accept) begin
        x_q     <= x_i;
        y_q     <= y_i;
        acc_q   <= '0;
        state_q <= first_d;
        if (first_d == DONE) begin
          p_q         <= '0;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul64_seq_ctrl.sv
// Self-checking bench for mul64_seq_ctrl: vector table, corner sequences, random vs. model.
// dut0 uses SKIP_ZERO=1, dut1 uses SKIP_ZERO=0.

module tb_mul64_seq_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0]  x [2];
  logic [63:0]  y [2];
  logic [127:0] p [2];
`ifdef MUL_SEQ_TAG_EN
  logic [3:0]   tag_i [2];
  logic [3:0]   tag_o [2];
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mul64_seq_ctrl #(.SKIP_ZERO(1)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .x_i(x[0]), .y_i(y[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .p_o(p[0]),
`ifdef MUL_SEQ_TAG_EN
    .tag_i(tag_i[0]), .tag_o(tag_o[0]),
`endif
    .busy(busy[0])
  );

  mul64_seq_ctrl #(.SKIP_ZERO(0)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .x_i(x[1]), .y_i(y[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .p_o(p[1]),
`ifdef MUL_SEQ_TAG_EN
    .tag_i(tag_i[1]), .tag_o(tag_o[1]),
`endif
    .busy(busy[1])
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: the product is plain 128-bit arithmetic; latency is one cycle per
  // partial product whose two operand halves are both nonzero (all four without skipping), plus one.
  function automatic logic [127:0] model_p(input logic [63:0] a, input logic [63:0] b);
    return {64'b0, a} * {64'b0, b};
  endfunction

  function automatic int model_lat(input int w, input logic [63:0] a, input logic [63:0] b);
    int n;
    logic [31:0] xh [2];
    logic [31:0] yh [2];
    xh[0] = a[31:0]; xh[1] = a[63:32];
    yh[0] = b[31:0]; yh[1] = b[63:32];
    n = 0;
    foreach (xh[i]) foreach (yh[j]) if (w == 1 || (xh[i] != 0 && yh[j] != 0)) n++;
    return n + 1;
  endfunction

  function automatic logic [31:0] rhalf();
    return ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
  endfunction

  task automatic txn(input int w, input logic [63:0] a, input logic [63:0] b,
                     input logic [127:0] ep, input int el, input string nm);
    int lat, g;
    g = 0;
    @(negedge clk);
    while (!in_ready[w] && g < 20) begin @(negedge clk); g++; end
    in_valid[w] = 1'b1; x[w] = a; y[w] = b;
    @(posedge clk);
    @(negedge clk);
    in_valid[w] = 1'b0;
    lat = 1;
    while (!out_valid[w] && lat < 20) begin @(negedge clk); lat++; end
    chk({nm, " p"}, p[w], ep);
    chk({nm, " latency"}, 128'(lat), 128'(el));
  endtask

  typedef struct {
    int           w;
    logic [63:0]  x;
    logic [63:0]  y;
    logic [127:0] p;
    int           lat;
    string        nm;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
               128'hFFFFFFFFFFFFFFFE0000000000000001, 5, "max"};
    tbl[1] = '{0, 64'd3, 64'd5, 128'd15, 2, "ll_only"};
    tbl[2] = '{0, 64'd0, 64'h1234, 128'd0, 1, "all_skip"};
    tbl[3] = '{0, 64'h0000000100000000, 64'h2, 128'h200000000, 2, "hl_only"};
    tbl[4] = '{1, 64'd3, 64'd5, 128'd15, 5, "noskip"};
    tbl[5] = '{0, 64'h0000000200000003, 64'h0000000500000007,
               128'h0000000A0000001D00000015, 5, "all_steps"};

    reset = 1'b1;
    in_valid = '0; out_ready = 2'b11;
    x[0] = '0; x[1] = '0; y[0] = '0; y[1] = '0;
`ifdef MUL_SEQ_TAG_EN
    tag_i[0] = '0; tag_i[1] = '0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst out_valid", 128'(out_valid[0]), 128'd0);
    chk("rst p", p[0], 128'd0);
    chk("rst busy", 128'(busy[0]), 128'd0);
    chk("rst in_ready", 128'(in_ready[0]), 128'd1);
`ifdef MUL_SEQ_TAG_EN
    chk("rst tag", 128'(tag_o[0]), 128'd0);
`endif

    foreach (tbl[i]) txn(tbl[i].w, tbl[i].x, tbl[i].y, tbl[i].p, tbl[i].lat, tbl[i].nm);

    // Backpressure then back-to-back accept in the draining cycle.
    @(negedge clk);
    in_valid[0] = 1'b1; x[0] = 64'd3; y[0] = 64'd5; out_ready[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("bp out_valid", 128'(out_valid[0]), 128'd1);
      chk("bp p", p[0], 128'd15);
      chk("bp in_ready", 128'(in_ready[0]), 128'd0);
      @(negedge clk);
    end
    out_ready[0] = 1'b1; in_valid[0] = 1'b1; x[0] = 64'd7; y[0] = 64'd9;
    #1;
    chk("b2b in_ready", 128'(in_ready[0]), 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    chk("b2b out_valid drop", 128'(out_valid[0]), 128'd0);
    chk("b2b busy", 128'(busy[0]), 128'd1);
    @(negedge clk);
    chk("b2b out_valid", 128'(out_valid[0]), 128'd1);
    chk("b2b p", p[0], 128'd63);

    // Reset during the HL step of a max-operand request.
    @(negedge clk);
    in_valid[0] = 1'b1; x[0] = '1; y[0] = '1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst out_valid", 128'(out_valid[0]), 128'd0);
    chk("midrst p", p[0], 128'd0);
    chk("midrst busy", 128'(busy[0]), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst no stale", 128'(out_valid[0]), 128'd0);
    end
    txn(0, 64'd2, 64'd3, 128'd6, 2, "post_rst");

    for (int i = 0; i < 40; i++) begin
      int w;
      logic [63:0] a, b;
      w = (i < 30) ? 0 : 1;
      a = {rhalf(), rhalf()};
      b = {rhalf(), rhalf()};
      txn(w, a, b, model_p(a, b), model_lat(w, a, b), $sformatf("rnd%0d", i));
    end

`ifdef MUL_SEQ_TAG_EN
    @(negedge clk);
    in_valid[0] = 1'b1; x[0] = 64'd3; y[0] = 64'd5; tag_i[0] = 4'hA;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("tag A p", p[0], 128'd15);
    chk("tag A", 128'(tag_o[0]), 128'hA);
    in_valid[0] = 1'b1; x[0] = 64'd7; y[0] = 64'd9; tag_i[0] = 4'h5;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("tag 5 p", p[0], 128'd63);
    chk("tag 5", 128'(tag_o[0]), 128'h5);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
